fifo_stream_reader: RTL and testbench

Read-side consumer for the team's asynchronous FIFO.
- Runs entirely in the read clock domain.
- Drains the FIFO through its rd_en/empty/dout interface, absorbing the FIFO's one-cycle read latency.
- Presents words downstream on a valid/ready stream, framed into fixed-length bursts.
- Guarantees the FIFO never sees a read while empty, so the FIFO's underflow flag never fires.

---
 rtl/fifo_stream_reader.sv | 165 ++++++++++++++++
 tb/tb_fifo_stream_reader.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : fifo_stream_reader
// Purpose  : Read-domain consumer for the async FIFO. Drains the FIFO through
//            rd_en/empty/dout (one-cycle read latency), buffers up to two
//            words and presents them on a valid/ready stream framed into
//            BURST_LEN-beat bursts. Never reads the FIFO while it is empty.
// Options  : `define SEQ_CHECK_EN adds the seq_err port and a sequence checker
//            that compares each popped word with previous + SEQ_STEP.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 7,
    parameter int SEQ_STEP   = 10
) (
    input  logic                  rd_clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic [15:0]           word_count,
    output logic                  busy
`ifdef SEQ_CHECK_EN
    ,
    output logic                  seq_err
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

    state_t                state;
    state_t                state_next;
    logic [DATA_WIDTH-1:0] buf_mem [2];
    logic                  head;
    logic                  tail;
    logic [1:0]            buf_cnt;
    logic                  pending;
    logic                  pop;
    logic [2:0]            credit;
    logic [7:0]            beat_cnt;

    // Words buffered plus the one in flight, after this cycle's pop leaves.
    assign pop    = m_valid && m_ready;
    assign credit = {1'b0, buf_cnt} + {2'b00, pending} - {2'b00, pop};

    // A read strobe during reset would pull a word that reset then throws
    // away, so reads are also held off while rst is high.
    assign fifo_rd_en = (state == ST_RUN) && !fifo_empty && (credit < 3'd2) && !rst;

    assign busy    = (state != ST_IDLE);
    assign m_valid = (buf_cnt != 2'd0);
    assign m_data  = m_valid ? buf_mem[head] : '0;
    assign m_last  = m_valid && (beat_cnt == LAST_BEAT);

    // State register.
    always_ff @(posedge rd_clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: DRAIN waits for the in-flight word and the buffer.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (enable) state_next = ST_RUN;
            ST_RUN:   if (!enable) state_next = ST_DRAIN;
            ST_DRAIN: begin
                if (enable) begin
                    state_next = ST_RUN;
                end else if (!pending && (buf_cnt == 2'd0)) begin
                    state_next = ST_IDLE;
                end
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    // Buffer storage: capture FIFO data one cycle after the read strobe.
    always_ff @(posedge rd_clk) begin
        if (pending && !rst) begin
            buf_mem[tail] <= fifo_dout;
        end
    end

    // Buffer pointers, occupancy and the in-flight read flag.
    always_ff @(posedge rd_clk) begin
        if (rst) begin
            head    <= 1'b0;
            tail    <= 1'b0;
            buf_cnt <= 2'd0;
            pending <= 1'b0;
        end else begin
            pending <= fifo_rd_en;
            if (pending) tail <= ~tail;
            if (pop)     head <= ~head;
            case ({pending, pop})
                2'b10:   buf_cnt <= buf_cnt + 2'd1;
                2'b01:   buf_cnt <= buf_cnt - 2'd1;
                default: buf_cnt <= buf_cnt;
            endcase
        end
    end

    // Burst position and total accepted beats; both advance on each pop.
    always_ff @(posedge rd_clk) begin
        if (rst) begin
            beat_cnt   <= 8'd0;
            word_count <= 16'd0;
        end else if (pop) begin
            word_count <= word_count + 16'd1;
            beat_cnt   <= (beat_cnt == LAST_BEAT) ? 8'd0 : beat_cnt + 8'd1;
        end
    end

`ifdef SEQ_CHECK_EN
    localparam logic [DATA_WIDTH-1:0] STEP = DATA_WIDTH'(SEQ_STEP);

    logic                  have_prev;
    logic [DATA_WIDTH-1:0] prev_word;
    logic [7:0]            err_cnt;
    logic                  mismatch;

    assign mismatch = have_prev && (m_data != prev_word + STEP);

    // Sequence checker: one-cycle error pulse and saturating error count.
    always_ff @(posedge rd_clk) begin
        if (rst) begin
            have_prev <= 1'b0;
            prev_word <= '0;
            err_cnt   <= 8'd0;
            seq_err   <= 1'b0;
        end else begin
            seq_err <= pop && mismatch;
            if (pop) begin
                have_prev <= 1'b1;
                prev_word <= m_data;
            end
            if (pop && mismatch && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end
`else
    // SEQ_STEP only matters to the sequence checker; keep it referenced.
    logic [DATA_WIDTH-1:0] seq_step_unused;
    assign seq_step_unused = DATA_WIDTH'(SEQ_STEP);
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_stream_reader
// Purpose  : Self-checking bench for fifo_stream_reader. A queue-based FIFO
//            model feeds the DUT; a scoreboard of words leaving the FIFO
//            predicts the stream order, burst framing and beat count.
// Options  : `define SEQ_CHECK_EN also exercises the sequence checker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_reader;

    localparam int DATA_WIDTH = 8;
    localparam int BURST_LEN  = 7;
    localparam int SEQ_STEP   = 10;

    logic                  rd_clk = 1'b0;
    logic                  rst;
    logic                  enable;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_rd_en;
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;
    logic                  m_ready;
    logic [15:0]           word_count;
    logic                  busy;
`ifdef SEQ_CHECK_EN
    logic                  seq_err;
`endif

    always #5 rd_clk = ~rd_clk;

    fifo_stream_reader #(
        .DATA_WIDTH (DATA_WIDTH),
        .BURST_LEN  (BURST_LEN),
        .SEQ_STEP   (SEQ_STEP)
    ) dut (
        .rd_clk     (rd_clk),
        .rst        (rst),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_last     (m_last),
        .m_ready    (m_ready),
        .word_count (word_count),
        .busy       (busy)
`ifdef SEQ_CHECK_EN
        ,
        .seq_err    (seq_err)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [7:0] fifo_q [$];
    logic [7:0] sb [$];
    logic [7:0] log_data [$];
    int         log_cyc [$];
    bit         log_last [$];
    int         pops = 0;
    int         beat = 0;
    int         outstanding = 0;
    int         reads = 0;
    int         cyc = 0;
    bit         stalled = 0;
    logic [7:0] stall_data = 8'd0;
    int         first_rd_cyc = -1;
    int         first_valid_cyc = -1;
    int         ready_mode = 0;
    int         ready_ph = 0;
    bit         underflow = 0;
    bit         have_prev = 0;
    logic [7:0] prev_word = 8'd0;
    bit         exp_seq_err = 0;
    int         seq_pulses = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: check at the falling edge, then update the FIFO model
    // and drive the next cycle's inputs just after the rising edge.
    task automatic tick();
        bit         do_read;
        bit         do_pop;
        bit         rst_now;
        logic [7:0] nxt;
        @(negedge rd_clk);
        cyc++;
        do_pop  = m_valid && m_ready;
        do_read = fifo_rd_en;
        rst_now = rst;
        check_val("rd_en_while_empty", 32'(fifo_rd_en && fifo_empty), 32'd0);
        if (do_read && fifo_empty) underflow = 1;
        if (do_read && first_rd_cyc < 0) first_rd_cyc = cyc;
        if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        check_val("word_count", 32'(word_count), 32'(pops % 65536));
        check_val("m_last", 32'(m_last), 32'(m_valid && (beat == BURST_LEN - 1)));
        if (stalled) begin
            check_val("stall_valid", 32'(m_valid), 32'd1);
            check_val("stall_data", 32'(m_data), 32'(stall_data));
        end
`ifdef SEQ_CHECK_EN
        check_val("seq_err", 32'(seq_err), 32'(exp_seq_err));
        if (seq_err) seq_pulses++;
`endif
        exp_seq_err = 0;
        if (do_pop) begin
            if (sb.size() == 0) begin
                check_val("valid_with_nothing_expected", 32'(m_valid), 32'd0);
            end else begin
                check_val("m_data", 32'(m_data), 32'(sb[0]));
                void'(sb.pop_front());
            end
            log_data.push_back(m_data);
            log_cyc.push_back(cyc);
            log_last.push_back(m_last);
            nxt = prev_word + 8'(SEQ_STEP);
            exp_seq_err = have_prev && (m_data != nxt);
            have_prev = 1;
            prev_word = m_data;
            pops++;
            beat = (beat + 1) % BURST_LEN;
        end
        if (do_read) reads++;
        outstanding += (do_read ? 1 : 0) - (do_pop ? 1 : 0);
        check_val("outstanding_le_2", 32'(outstanding <= 2), 32'd1);
        stalled    = m_valid && !m_ready;
        stall_data = m_data;
        @(posedge rd_clk);
        #1;
        if (do_read && fifo_q.size() > 0) begin
            fifo_dout = fifo_q.pop_front();
            sb.push_back(fifo_dout);
        end
        if (rst_now) begin
            sb.delete();
            pops = 0; beat = 0; outstanding = 0; stalled = 0;
            first_rd_cyc = -1; first_valid_cyc = -1;
            have_prev = 0; exp_seq_err = 0;
        end
        fifo_empty = (fifo_q.size() == 0);
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       begin m_ready = ((ready_ph % 4) == 0) || ((ready_ph % 4) == 3); ready_ph++; end
            2:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b0;
        endcase
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enable = 1'b0;
        tick();
        rst = 1'b0;
        check_val("rst_m_valid", 32'(m_valid), 32'd0);
        check_val("rst_word_count", 32'(word_count), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_m_last", 32'(m_last), 32'd0);
        check_val("rst_m_data", 32'(m_data), 32'd0);
        check_val("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        reads = 0;
        log_data.delete(); log_cyc.delete(); log_last.delete();
    endtask

    task automatic load_seq(input int start, input int step, input int n);
        fifo_q.delete();
        for (int i = 0; i < n; i++) fifo_q.push_back(8'(start + i * step));
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic set_ready(input int mode);
        ready_mode = mode;
        ready_ph   = 1;
        m_ready    = (mode == 0 || mode == 1);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; fifo_empty = 1'b1; fifo_dout = 8'd0; m_ready = 1'b0;
        @(posedge rd_clk);
        @(posedge rd_clk);
        #1;
        do_reset();

        // 1: straight burst at full throughput
        load_seq(10, 10, 7);
        set_ready(0);
        enable = 1'b1;
        repeat (20) tick();
        check_val("t1_count", 32'(log_data.size()), 32'd7);
        if (log_data.size() == 7) begin
            for (int i = 0; i < 7; i++) begin
                check_val("t1_data", 32'(log_data[i]), 32'(10 * (i + 1)));
                check_val("t1_last", 32'(log_last[i]), 32'(i == 6));
                if (i > 0) check_val("t1_back_to_back", 32'(log_cyc[i] - log_cyc[i-1]), 32'd1);
            end
        end
        check_val("t1_word_count", 32'(word_count), 32'd7);
        check_val("t1_first_latency", 32'(first_valid_cyc - first_rd_cyc), 32'd2);

        // 2: back-pressure pattern 1,0,0,1
        do_reset();
        load_seq(10, 10, 7);
        set_ready(1);
        enable = 1'b1;
        repeat (40) tick();
        check_val("t2_count", 32'(log_data.size()), 32'd7);
        if (log_data.size() == 7) begin
            for (int i = 0; i < 7; i++) check_val("t2_data", 32'(log_data[i]), 32'(10 * (i + 1)));
        end
        check_val("t2_sb_empty", 32'(sb.size()), 32'd0);

        // 3: FIFO empty throughout
        do_reset();
        fifo_q.delete();
        fifo_empty = 1'b1;
        set_ready(0);
        enable = 1'b1;
        repeat (6) tick();
        check_val("t3_busy", 32'(busy), 32'd1);
        check_val("t3_m_valid", 32'(m_valid), 32'd0);
        check_val("t3_rd_en", 32'(fifo_rd_en), 32'd0);
        enable = 1'b0;
        repeat (2) tick();
        check_val("t3_idle", 32'(busy), 32'd0);

        // 4: drop enable after three reads, drain, then resume the burst
        do_reset();
        load_seq(10, 10, 7);
        set_ready(0);
        enable = 1'b1;
        repeat (3) tick();
        enable = 1'b0;
        tick();
        check_val("t4_reads", 32'(reads), 32'd3);
        check_val("t4_drain_busy", 32'(busy), 32'd1);
        check_val("t4_drain_no_rd", 32'(fifo_rd_en), 32'd0);
        for (int i = 0; i < 20 && busy; i++) tick();
        check_val("t4_idle_in_time", 32'(busy), 32'd0);
        check_val("t4_delivered", 32'(log_data.size()), 32'd3);
        check_val("t4_sb_empty", 32'(sb.size()), 32'd0);
        enable = 1'b1;
        repeat (15) tick();
        check_val("t4_total", 32'(log_data.size()), 32'd7);
        if (log_data.size() == 7) begin
            check_val("t4_beat7_data", 32'(log_data[6]), 32'd70);
            check_val("t4_beat7_last", 32'(log_last[6]), 32'd1);
            check_val("t4_beat3_last", 32'(log_last[2]), 32'd0);
        end

        // 5: reset with one word buffered and one in flight
        load_seq(10, 10, 7);
        set_ready(3);
        repeat (2) tick();
        check_val("t5_pre_valid", 32'(m_valid), 32'd1);
        check_val("t5_pre_count", 32'(word_count), 32'd7);
        do_reset();
        set_ready(0);
        enable = 1'b1;
        repeat (20) tick();
        check_val("t5_count", 32'(log_data.size()), 32'd5);
        if (log_data.size() > 0) check_val("t5_first_after_rst", 32'(log_data[0]), 32'd30);

`ifdef SEQ_CHECK_EN
        // 6: sequence checker
        do_reset();
        load_seq(10, 10, 2);
        fifo_q.push_back(8'd35);
        fifo_q.push_back(8'd45);
        set_ready(0);
        seq_pulses = 0;
        enable = 1'b1;
        repeat (12) tick();
        check_val("t6_seq_pulses", 32'(seq_pulses), 32'd1);
        check_val("t6_err_cnt", 32'(dut.err_cnt), 32'd1);
`endif

        // Random traffic, enable toggling and occasional resets
        do_reset();
        set_ready(2);
        enable = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            tick();
            if (($urandom % 2 == 0) && fifo_q.size() < 12) begin
                fifo_q.push_back(8'($urandom));
                fifo_empty = 1'b0;
            end
            if ($urandom % 25 == 0) enable = ~enable;
            if ($urandom % 400 == 0) begin
                do_reset();
                enable = 1'b1;
            end
        end
        enable = 1'b1;
        set_ready(0);
        repeat (40) tick();
        check_val("rand_fifo_drained", 32'(fifo_q.size()), 32'd0);
        check_val("rand_sb_empty", 32'(sb.size()), 32'd0);
        check_val("rand_m_valid", 32'(m_valid), 32'd0);
        check_val("fifo_underflow", 32'(underflow), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
